// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: the BTB entry layout, the 2-bit direction
// counter with its saturating helpers, and the IF/ID bundle.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Widest tag (a two-entry BTB); narrower tags are zero-extended.
  localparam int TAG_MAX = 29;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_t;

  typedef struct packed {
    logic               valid;
    logic [TAG_MAX-1:0] tag;
    logic [31:0]        target;
    ctr_t               ctr;
  } btb_entry_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        valid;
  } ifid_t;

  function automatic ctr_t ctr_inc(input ctr_t c);
    return (c == STRONG_T) ? STRONG_T : ctr_t'(c + 2'd1);
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    return (c == STRONG_NT) ? STRONG_NT : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// posedge update from the execute stage's resolved branch.
module fetch_btb
  import fetch_pkg::*;
#(
  parameter int BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_f,
  output logic        pred_taken_f,
  output logic [31:0] pred_target_f,
  input  logic        bp_update_e,
  input  logic [31:0] bp_pc_e,
  input  logic        bp_taken_e,
  input  logic [31:0] bp_target_e
);

  localparam int IW = $clog2(BTB_ENTRIES);

  btb_entry_t btb_q [BTB_ENTRIES];

  logic [IW-1:0]      look_idx;
  logic [TAG_MAX-1:0] look_tag;
  btb_entry_t         look_entry;
  logic [IW-1:0]      upd_idx;
  logic [TAG_MAX-1:0] upd_tag;
  btb_entry_t         upd_entry;
  btb_entry_t         wr_entry_d;
  logic               wr_en;
  logic               unused_lo;

  assign unused_lo = ^{pc_f[1:0], bp_pc_e[1:0]};

  // Lookup reads the array before this cycle's update lands.
  always_comb begin
    look_idx      = pc_f[IW+1:2];
    look_tag      = TAG_MAX'(pc_f[31:IW+2]);
    look_entry    = btb_q[look_idx];
    pred_taken_f  = look_entry.valid && (look_entry.tag == look_tag) && look_entry.ctr[1];
    pred_target_f = pred_taken_f ? look_entry.target : pc_f + 32'd4;
  end

  // NOTE: every variable gets a default before the if-chain so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    upd_idx    = bp_pc_e[IW+1:2];
    upd_tag    = TAG_MAX'(bp_pc_e[31:IW+2]);
    upd_entry  = btb_q[upd_idx];
    wr_entry_d = upd_entry;
    wr_en      = 1'b0;
    if (bp_update_e) begin
      if (upd_entry.valid && (upd_entry.tag == upd_tag)) begin
        wr_en = 1'b1;
        if (bp_taken_e) begin
          wr_entry_d.ctr    = ctr_inc(upd_entry.ctr);
          wr_entry_d.target = bp_target_e;
        end else begin
          wr_entry_d.ctr = ctr_dec(upd_entry.ctr);
        end
      end else if (bp_taken_e) begin
        wr_en      = 1'b1;
        wr_entry_d = '{valid: 1'b1, tag: upd_tag, target: bp_target_e, ctr: WEAK_T};
      end
    end
  end

  // NOTE: only the valid bits are reset; tag/target/ctr are never read while
  // valid is low, so the payload RAM needs no reset. Non-blocking assignments
  // keep the lookup above seeing pre-update contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_q[i].valid <= 1'b0;
    end else if (wr_en) begin
      btb_q[upd_idx] <= wr_entry_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, optional BTB predictor and IF/ID register.
// Define FETCH_BPRED_EN to build the BTB; otherwise fetch is always sequential.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16,
  parameter logic [31:0] NOP_INSTR   = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_f,
  output logic [31:0] pc_f,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        redirect_e,
  input  logic [31:0] redirect_pc_e,
  input  logic        bp_update_e,
  input  logic [31:0] bp_pc_e,
  input  logic        bp_taken_e,
  input  logic [31:0] bp_target_e,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        pred_taken_d,
  output logic [31:0] pred_pc_d,
  output logic        valid_d
);

  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0,
                                    pred_taken: 1'b0, pred_pc: '0, valid: 1'b0};

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc_plus4_f;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  ifid_t       ifid_q, ifid_d;

  assign pc_plus4_f = fetch_pc_q + 32'd4;

`ifdef FETCH_BPRED_EN
  fetch_btb #(
    .BTB_ENTRIES(BTB_ENTRIES)
  ) u_btb (
    .clk          (clk),
    .rst          (rst),
    .pc_f         (fetch_pc_q),
    .pred_taken_f (pred_taken_f),
    .pred_target_f(pred_target_f),
    .bp_update_e  (bp_update_e),
    .bp_pc_e      (bp_pc_e),
    .bp_taken_e   (bp_taken_e),
    .bp_target_e  (bp_target_e)
  );
`else
  logic unused_bp;
  assign unused_bp     = ^{bp_update_e, bp_pc_e, bp_taken_e, bp_target_e, BTB_ENTRIES[0]};
  assign pred_taken_f  = 1'b0;
  assign pred_target_f = pc_plus4_f;
`endif

  // A redirect corrects the PC even while fetch is stalled.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_e) begin
      fetch_pc_d = redirect_pc_e;
    end else if (!stall_f) begin
      fetch_pc_d = pred_taken_f ? pred_target_f : pc_plus4_f;
    end
  end

  always_comb begin
    ifid_d = ifid_q;
    if (flush_d || redirect_e) begin
      ifid_d = IFID_BUBBLE;
    end else if (!stall_d) begin
      ifid_d = '{instr: instr_f, pc: fetch_pc_q, pc_plus4: pc_plus4_f,
                 pred_taken: pred_taken_f, pred_pc: pred_target_f, valid: 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      ifid_q     <= IFID_BUBBLE;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      ifid_q     <= ifid_d;
    end
  end

  assign pc_f         = fetch_pc_q;
  assign instr_d      = ifid_q.instr;
  assign pc_d         = ifid_q.pc;
  assign pc_plus4_d   = ifid_q.pc_plus4;
  assign pred_taken_d = ifid_q.pred_taken;
  assign pred_pc_d    = ifid_q.pred_pc;
  assign valid_d      = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural model predicts pc_f and the
// IF/ID bundle for every cycle; a monitor compares after each clock edge.
module tb_fetch_stage;

  localparam int N  = 16;
  localparam int IW = $clog2(N);
`ifdef FETCH_BPRED_EN
  localparam bit BPRED = 1'b1;
`else
  localparam bit BPRED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_f, pc_f;
  logic        stall_f, stall_d, flush_d, redirect_e;
  logic [31:0] redirect_pc_e;
  logic        bp_update_e, bp_taken_e;
  logic [31:0] bp_pc_e, bp_target_e;
  logic [31:0] instr_d, pc_d, pc_plus4_d, pred_pc_d;
  logic        pred_taken_d, valid_d;

  fetch_stage dut (
    .clk(clk), .rst(rst), .instr_f(instr_f), .pc_f(pc_f),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .redirect_e(redirect_e), .redirect_pc_e(redirect_pc_e),
    .bp_update_e(bp_update_e), .bp_pc_e(bp_pc_e), .bp_taken_e(bp_taken_e),
    .bp_target_e(bp_target_e), .instr_d(instr_d), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d), .pred_taken_d(pred_taken_d),
    .pred_pc_d(pred_pc_d), .valid_d(valid_d)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) + {a[15:0], a[31:16]} + 32'h0000_1000;
  endfunction

  assign instr_f = imem(pc_f);

  typedef struct {
    logic [31:0] pc_f, instr, pc, pc4, ppc;
    logic        ptaken, valid;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] m_pc;
  bit          m_valid[N];
  logic [31:0] m_tag[N], m_target[N];
  int          m_ctr[N];
  exp_t        m_ifid;

  task automatic model_step();
    int          idx;
    logic [31:0] tag, ptarget;
    bit          ptaken, hit;
    exp_t        e;
    if (!rst) begin
      m_pc = 32'h0;
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
      m_ifid = '{pc_f: 0, instr: 32'h13, pc: 0, pc4: 0, ppc: 0, ptaken: 0, valid: 0};
    end else begin
      idx     = int'((m_pc >> 2) % N);
      tag     = m_pc >> (2 + IW);
      ptaken  = BPRED && m_valid[idx] && m_tag[idx] == tag && m_ctr[idx] >= 2;
      ptarget = ptaken ? m_target[idx] : m_pc + 32'd4;
      if (flush_d || redirect_e)
        m_ifid = '{pc_f: 0, instr: 32'h13, pc: 0, pc4: 0, ppc: 0, ptaken: 0, valid: 0};
      else if (!stall_d)
        m_ifid = '{pc_f: 0, instr: imem(m_pc), pc: m_pc, pc4: m_pc + 32'd4,
                   ppc: ptarget, ptaken: ptaken, valid: 1};
      if (BPRED && bp_update_e) begin
        idx = int'((bp_pc_e >> 2) % N);
        tag = bp_pc_e >> (2 + IW);
        hit = m_valid[idx] && m_tag[idx] == tag;
        if (hit && bp_taken_e) begin
          m_ctr[idx]    = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
          m_target[idx] = bp_target_e;
        end else if (hit) begin
          m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
        end else if (bp_taken_e) begin
          m_valid[idx]  = 1'b1;
          m_tag[idx]    = tag;
          m_target[idx] = bp_target_e;
          m_ctr[idx]    = 2;
        end
      end
      if (redirect_e) m_pc = redirect_pc_e;
      else if (!stall_f) m_pc = ptarget;
    end
    e      = m_ifid;
    e.pc_f = m_pc;
    sb_q.push_back(e);
  endtask

  // Called with clk low: record the expectation, then wait for the next negedge.
  task automatic cycle();
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    stall_f = 0; stall_d = 0; flush_d = 0; redirect_e = 0; redirect_pc_e = 0;
    bp_update_e = 0; bp_pc_e = 0; bp_taken_e = 0; bp_target_e = 0;
  endtask

  task automatic train(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
    bp_update_e = 1; bp_pc_e = pc; bp_taken_e = taken; bp_target_e = tgt;
  endtask

  task automatic jump(input logic [31:0] pc);
    redirect_e = 1; redirect_pc_e = pc;
  endtask

  // Monitor: every edge produces one expected snapshot.
  exp_t got;
  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      got = sb_q.pop_front();
      check("pc_f", pc_f, got.pc_f);
      check("instr_d", instr_d, got.instr);
      check("pc_d", pc_d, got.pc);
      check("pc_plus4_d", pc_plus4_d, got.pc4);
      check("pred_taken_d", 32'(pred_taken_d), 32'(got.ptaken));
      check("pred_pc_d", pred_pc_d, got.ppc);
      check("valid_d", 32'(valid_d), 32'(got.valid));
    end
  end

  initial begin
    idle();
    rst = 0;
    cycle(); cycle();
    check("reset_pc", pc_f, 32'h0);
    check("reset_instr", instr_d, 32'h13);
    check("reset_valid", 32'(valid_d), 0);

    rst = 1;
    cycle();
    check("first_pc", pc_f, 32'h4);
    check("first_capture_valid", 32'(valid_d), 1);
    cycle(); cycle(); cycle();
    check("seq_pc", pc_f, 32'h10);

    stall_f = 1; stall_d = 1;
    repeat (3) cycle();
    check("stall_pc", pc_f, 32'h10);
    check("stall_pc_d", pc_d, 32'hC);
    idle();
    cycle();
    check("release_pc", pc_f, 32'h14);

    flush_d = 1; stall_d = 1; stall_f = 1;
    cycle();
    check("flush_stall_instr", instr_d, 32'h13);
    check("flush_stall_valid", 32'(valid_d), 0);
    check("flush_stall_pred", 32'(pred_taken_d), 0);
    idle();

    jump(32'h200); stall_f = 1; stall_d = 1;
    cycle();
    check("redirect_pc", pc_f, 32'h200);
    check("redirect_bubble", 32'(valid_d), 0);
    idle();

    train(32'h40, 1, 32'h100); jump(32'h40);
    cycle(); idle();
    cycle();
    check("train_pred", 32'(pred_taken_d), 32'(BPRED));
    check("train_pred_pc", pred_pc_d, BPRED ? 32'h100 : 32'h44);
    check("train_jump", pc_f, BPRED ? 32'h100 : 32'h44);
    train(32'h40, 0, 32'h0);
    cycle();
    train(32'h40, 0, 32'h0); jump(32'h40);
    cycle(); idle();
    cycle();
    check("untrain_pred", 32'(pred_taken_d), 0);
    check("untrain_pred_pc", pred_pc_d, 32'h44);

    train(32'h40, 1, 32'h100);
    cycle();
    train(32'h40, 1, 32'h100); jump(32'h40);
    cycle(); idle();
    cycle();
    check("retrain_pred", 32'(pred_taken_d), 32'(BPRED));
    train(32'h80, 1, 32'h300); jump(32'h40);
    cycle(); idle();
    cycle();
    check("alias_pred", 32'(pred_taken_d), 0);
    check("alias_pred_pc", pred_pc_d, 32'h44);

    for (int i = 0; i < 800; i++) begin
      rst           = ($urandom_range(0, 199) != 0);
      stall_d       = ($urandom_range(0, 5) == 0);
      stall_f       = stall_d;
      flush_d       = ($urandom_range(0, 11) == 0);
      redirect_e    = ($urandom_range(0, 9) == 0);
      redirect_pc_e = 32'($urandom_range(0, 127)) << 2;
      bp_update_e   = ($urandom_range(0, 2) == 0);
      bp_pc_e       = ($urandom_range(0, 1) != 0) ? m_pc : 32'($urandom_range(0, 63)) << 2;
      bp_taken_e    = ($urandom_range(0, 3) != 0);
      bp_target_e   = 32'($urandom_range(0, 127)) << 2;
      cycle();
    end
    rst = 1;
    idle();
    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
